// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Drains a registered-read FIFO (data valid one cycle after
//                rd_en) and presents its words as a valid/ready stream at up
//                to one word per cycle. A two-entry output buffer absorbs the
//                FIFO read latency under backpressure. Accepted beats are
//                counted in a free-running, wrapping counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    // A new read may be issued only if, after this cycle's pop and the
    // arrival of any read in flight, at most one slot is taken. The read then
    // lands next cycle without ever overflowing the two-entry buffer.
    localparam logic [2:0] c_RD_LIMIT = 3'd1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             r_occ;      // words held in the buffer (0..2)
    logic                   r_pend;     // a FIFO read was issued last cycle
    logic                   r_valid;    // registered stream valid
    logic [DATA_WIDTH-1:0]  r_buf0;     // head entry, drives m_data
    logic [DATA_WIDTH-1:0]  r_buf1;     // second entry
    logic [COUNT_WIDTH-1:0] r_beats;    // accepted beat counter

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic                   w_pop;
    logic [2:0]             w_occ_after_pop;
    logic [2:0]             w_fill;
    logic                   w_rd_en;
    logic [DATA_WIDTH-1:0]  w_buf0_next;
    logic [DATA_WIDTH-1:0]  w_buf1_next;

    // Occupancy bookkeeping and the read-issue decision. The m_ready ->
    // fifo_rd_en path is deliberate: it lets a read go out in the same cycle
    // a slot is freed, which is what sustains one beat per cycle.
    always_comb begin
        w_pop           = r_valid & m_ready;
        // r_valid implies r_occ != 0, so this never underflows.
        w_occ_after_pop = {1'b0, r_occ} - {2'b00, w_pop};
        w_fill          = w_occ_after_pop + {2'b00, r_pend};
        w_rd_en         = enable & ~fifo_empty & ~reset & (w_fill <= c_RD_LIMIT);
    end

    // Buffer datapath: shift out the head on a pop, then drop an arriving
    // word into the first free slot behind whatever remains, keeping order.
    always_comb begin
        w_buf0_next = w_pop ? r_buf1 : r_buf0;
        w_buf1_next = r_buf1;
        if (r_pend) begin
            if (w_occ_after_pop == 3'd0) begin
                w_buf0_next = fifo_data;
            end else begin
                w_buf1_next = fifo_data;
            end
        end
    end

    // Registered state: occupancy, read-in-flight flag, buffer, valid, count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ   <= 2'd0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_beats <= '0;
        end else begin
            r_occ   <= w_fill[1:0];
            r_pend  <= w_rd_en;
            r_valid <= (w_fill != 3'd0);
            r_buf0  <= w_buf0_next;
            r_buf1  <= w_buf1_next;
            if (w_pop) begin
                r_beats <= r_beats + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // While stalled (valid && !ready) there is no pop and any arrival goes
    // to slot 1 because occupancy is already nonzero, so the head holds.
    assign fifo_rd_en = w_rd_en;
    assign m_data     = r_buf0;
    assign m_valid    = r_valid;
    assign beat_count = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed bench for fifo_stream_reader with a behavioural
//                registered-read FIFO and a scoreboard of expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int c_DW = 32;
    localparam int c_CW = 32;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            fifo_empty;
    logic [c_DW-1:0] fifo_data;
    logic            fifo_rd_en;
    logic [c_DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic [c_CW-1:0] beat_count;

    fifo_stream_reader #(.DATA_WIDTH(c_DW), .COUNT_WIDTH(c_CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural FIFO contents and the scoreboard of words the stream owes.
    logic [c_DW-1:0] fifo_q[$];
    logic [c_DW-1:0] exp_q[$];

    int              cyc;
    int              rd_pulses;     // reads issued since the last reset
    int              beats;         // handshakes seen since the last reset
    int              first_rd;
    int              first_valid;
    logic            last_rd;
    logic            prev_stall;
    logic [c_DW-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs just after the falling edge, score any
    // handshake, then model the FIFO's registered read at the next fall.
    task automatic step();
        logic            rd;
        logic [c_DW-1:0] e;
        #1;
        rd      = fifo_rd_en;
        last_rd = rd;
        if (reset) check("rd_in_reset", {63'd0, rd}, 64'd0);
        if (rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
            check("no_underflow_read", {63'd0, fifo_empty}, 64'd0);
        end
        if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (prev_stall) check("data_hold", {32'd0, m_data}, {32'd0, prev_data});
        if (m_valid === 1'b1 && m_ready === 1'b1 && !reset) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {32'd0, m_data}, 64'hDEAD_BEEF_0000_0000);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", {32'd0, m_data}, {32'd0, e});
            end
            beats++;
        end
        if (!reset) check("outstanding_le_2", {63'd0, (rd_pulses - beats) <= 2}, 64'd1);
        prev_stall = (m_valid === 1'b1) && !m_ready && !reset;
        prev_data  = m_data;
        @(negedge clk);
        cyc++;
        if (reset) begin
            rd_pulses  = 0;
            beats      = 0;
            prev_stall = 1'b0;
            fifo_data  = '0;
        end else if (rd && fifo_q.size() != 0) begin
            fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input int n, input logic [c_DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + i[c_DW-1:0]);
            exp_q.push_back(base + i[c_DW-1:0]);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic reset_and_flush();
        reset = 1'b1;
        step();
        reset = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty  = 1'b1;
        first_rd    = -1;
        first_valid = -1;
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
        fifo_empty = 1'b1; fifo_data = '0;
        cyc = 0; rd_pulses = 0; beats = 0;
        first_rd = -1; first_valid = -1;
        last_rd = 1'b0; prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);

        // 1: reset held with a non-empty FIFO and enable high
        load(16, 32'h1000);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", {32'd0, m_data}, 64'd0);
        check("rst_beat_count", {32'd0, beat_count}, 64'd0);

        // 2: full-throughput drain of 16 preloaded words
        first_rd = -1; first_valid = -1;
        n = 0;
        while (beats < 16 && n < 60) begin step(); n++; end
        check("t2_beats_done", beats, 16);
        check("t2_latency", first_valid - first_rd, 2);
        check("t2_beat_count", {32'd0, beat_count}, 64'd16);
        check("t2_rd_pulses", rd_pulses, 16);
        check("t2_scoreboard_empty", exp_q.size(), 0);
        step();
        check("t2_valid_after_drain", {63'd0, m_valid}, 64'd0);

        // 3: backpressure from the start, then release
        reset_and_flush();
        m_ready = 1'b0;
        load(16, 32'h1000);
        for (int i = 0; i < 10; i++) step();
        check("t3_rd_pulses_stalled", rd_pulses, 2);
        check("t3_valid_stalled", {63'd0, m_valid}, 64'd1);
        check("t3_head_data", {32'd0, m_data}, 64'h1000);
        m_ready = 1'b1;
        n = 0;
        while (beats < 16 && n < 40) begin step(); n++; end
        check("t3_no_gap_cycles", n, 16);
        check("t3_beat_count", {32'd0, beat_count}, 64'd16);
        check("t3_scoreboard_empty", exp_q.size(), 0);

        // 4: m_ready toggling every cycle
        reset_and_flush();
        load(16, 32'h2000);
        n = 0;
        while (beats < 16 && n < 100) begin
            m_ready = (n % 2 == 0);
            step();
            n++;
        end
        m_ready = 1'b1;
        check("t4_beats_done", beats, 16);
        check("t4_beat_count", {32'd0, beat_count}, beats);
        check("t4_scoreboard_empty", exp_q.size(), 0);

        // 5: enable dropped after five reads, then restored
        reset_and_flush();
        load(16, 32'h1000);
        n = 0;
        while (rd_pulses < 5 && n < 20) begin step(); n++; end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_rd_disabled", {63'd0, last_rd}, 64'd0);
        end
        check("t5_beats_capped", beats, 5);
        check("t5_valid_drained", {63'd0, m_valid}, 64'd0);
        check("t5_next_expected", exp_q.size() != 0 ? {32'd0, exp_q[0]} : 64'd0, 64'h1005);
        enable = 1'b1;
        n = 0;
        while (beats < 16 && n < 60) begin step(); n++; end
        check("t5_beats_resumed", beats, 16);
        check("t5_beat_count", {32'd0, beat_count}, 64'd16);

        // 6: reset pulse with a full buffer and nothing in flight
        reset_and_flush();
        load(16, 32'h3000);
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t6_valid_before", {63'd0, m_valid}, 64'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t6_beats_before", {32'd0, beat_count}, 64'd3);
        reset_and_flush();
        check("t6_valid_after_reset", {63'd0, m_valid}, 64'd0);
        check("t6_count_after_reset", {32'd0, beat_count}, 64'd0);
        check("t6_data_after_reset", {32'd0, m_data}, 64'd0);

        // Clean restart after the mid-stream reset
        m_ready = 1'b1;
        load(4, 32'h4000);
        n = 0;
        while (beats < 4 && n < 30) begin step(); n++; end
        check("t6_restart_beats", beats, 4);
        check("t6_restart_count", {32'd0, beat_count}, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
